// File: rtl/mul_sequencer.sv
// Sequential shift-and-add multiplier: one multiplier bit per RUN cycle, optional early
// exit once the remaining multiplier bits are all zero. Result keeps the low WIDTH bits.
module mul_sequencer #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0] b_shift;
  logic             run_last;

  assign acc_sum  = b_q[0] ? (acc_q + a_q) : acc_q;
  assign b_shift  = b_q >> 1;
  assign run_last = (cnt_q == CNT_LAST) || (EARLY_EXIT && (b_shift == '0));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (abort)         state_nxt = IDLE;
        else if (run_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath registers; result only changes on the edge that enters DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= srca;
            b_q   <= srcb;
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          a_q   <= a_q << 1;
          b_q   <= b_shift;
          acc_q <= acc_sum;
          cnt_q <= cnt_q + 1'b1;
          if (!abort && run_last) result_q <= acc_sum;
        end
        default: ;
      endcase
    end
  end

  // Stall is combinational so the surrounding pipeline freezes in the cycle start rises.
  assign stall  = ((state == IDLE) && start) || (state == RUN);
  assign busy   = (state == RUN) || (state == DONE);
  assign done   = (state == DONE);
  assign result = result_q;
  assign n      = result_q[WIDTH-1];
  assign z      = (result_q == '0);

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: one instance with early exit, one without, sharing
// clock, reset and operand buses; per-vector latency, flags and protocol are checked.
module tb_mul_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, abort, sel_ee;
  logic [W-1:0] srca, srcb;

  logic         stall1, busy1, done1, n1, z1;
  logic         stall0, busy0, done0, n0, z0;
  logic [W-1:0] result1, result0;

  logic         start1, start0;
  logic         stall_s, busy_s, done_s, n_s, z_s;
  logic [W-1:0] result_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign start1   = start && sel_ee;
  assign start0   = start && !sel_ee;
  assign stall_s  = sel_ee ? stall1  : stall0;
  assign busy_s   = sel_ee ? busy1   : busy0;
  assign done_s   = sel_ee ? done1   : done0;
  assign n_s      = sel_ee ? n1      : n0;
  assign z_s      = sel_ee ? z1      : z0;
  assign result_s = sel_ee ? result1 : result0;

  mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_ee1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort),
    .srca(srca), .srcb(srcb), .stall(stall1), .busy(busy1),
    .done(done1), .result(result1), .n(n1), .z(z1)
  );

  mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_ee0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort),
    .srca(srca), .srcb(srcb), .stall(stall0), .busy(busy0),
    .done(done0), .result(result0), .n(n0), .z(z0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one multiply starting at the next negedge (cycle 0) and returns in the Done cycle.
  // p1/p2 are cycles in which a stray start pulse is raised; operands are scrambled after cycle 0.
  task automatic do_op(input string tag, input bit ee, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int exp_cyc, input logic [W-1:0] exp_res,
                       input int p1, input int p2);
    int cyc;
    int stall_cnt;
    bit seen;
    @(negedge clk);
    sel_ee = ee;
    start  = 1'b1;
    srca   = a;
    srcb   = b;
    #1;
    check({tag, "_c0_stall"}, stall_s, 1'b1);
    check({tag, "_c0_busy"}, busy_s, 1'b0);
    stall_cnt = 1;
    cyc       = 0;
    seen      = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start = (cyc == p1) || (cyc == p2);
      abort = 1'b0;
      srca  = $urandom;
      srcb  = $urandom;
      #1;
      if (done_s)       seen = 1'b1;
      else if (stall_s) stall_cnt++;
    end
    check({tag, "_latency"}, cyc, exp_cyc);
    check({tag, "_stall_cycles"}, stall_cnt, exp_cyc);
    check({tag, "_result"}, result_s, exp_res);
    check({tag, "_n"}, n_s, exp_res[W-1]);
    check({tag, "_z"}, z_s, exp_res == '0);
    check({tag, "_busy_done"}, busy_s, 1'b1);
  endtask

  initial begin
    bit any_done;
    reset  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    sel_ee = 1'b1;
    srca   = '0;
    srcb   = '0;
    #3;
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_stall", stall1, 1'b0);
    check("rst_result", result1, 32'h0);
    check("rst_n", n1, 1'b0);
    check("rst_z", z1, 1'b1);
    check("rst_result_ee0", result0, 32'h0);

    @(posedge clk);
    #2 reset = 1'b1;

    // Abort raised together with start in IDLE must not block acceptance.
    abort = 1'b1;
    do_op("m3x5", 1'b1, 32'd3, 32'd5, 4, 32'd15, -1, -1);
    do_op("mff", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h1, -1, -1);
    do_op("mb0", 1'b1, 32'h1234_5678, 32'h0, 2, 32'h0, -1, -1);
    do_op("mneg", 1'b1, 32'hFFFF_FFFE, 32'd3, 3, 32'hFFFF_FFFA, -1, -1);
    do_op("mmid", 1'b1, 32'h0000_FFFF, 32'h0001_0001, 18, 32'hFFFF_FFFF, -1, -1);
    do_op("full6x7", 1'b0, 32'd6, 32'd7, 33, 32'd42, 5, 33);

    // Abort in cycle 4 of a full-length run on the no-early-exit instance.
    @(negedge clk);
    sel_ee   = 1'b0;
    start    = 1'b1;
    srca     = 32'd9;
    srcb     = 32'hFFFF_FFFF;
    any_done = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (c == 4);
      #1;
      any_done |= done_s;
    end
    check("abort_idle_busy", busy_s, 1'b0);
    check("abort_idle_stall", stall_s, 1'b0);
    check("abort_result_held", result_s, 32'd42);
    check("abort_no_done", any_done, 1'b0);
    do_op("post_abort", 1'b0, 32'h0001_0001, 32'h0001_0001, 33, 32'h0002_0001, -1, -1);
    do_op("full_b0", 1'b0, 32'hDEAD_BEEF, 32'h0, 33, 32'h0, -1, -1);

    // Asynchronous reset in the middle of a RUN cycle.
    @(negedge clk);
    sel_ee = 1'b1;
    start  = 1'b1;
    srca   = 32'd7;
    srcb   = 32'hFFFF_FFFF;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    check("arst_busy", busy1, 1'b0);
    check("arst_result", result1, 32'h0);
    check("arst_z", z1, 1'b1);
    check("arst_result_ee0", result0, 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    any_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      any_done |= done1 | busy1;
    end
    check("arst_no_done", any_done, 1'b0);

    // Start in the very first cycle after releasing reset.
    @(posedge clk);
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    do_op("post_rst", 1'b1, 32'h8000_0000, 32'd1, 2, 32'h8000_0000, -1, -1);

    @(negedge clk);
    start = 1'b0;
    #1;
    check("final_idle", busy_s, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
